// File: rtl/stepper_mmio_if.sv
// Processor data-memory bus slice seen by the stepper controller.
// The master drives address, data and the store strobe; the slave returns load data and a window hit.
interface stepper_mmio_if;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_mmio;
  logic        hit;

  modport master (output wren, output address_dmem, output data, input q_mmio, input hit);
  modport slave  (input wren, input address_dmem, input data, output q_mmio, output hit);
endinterface

// File: rtl/stepper_mmio.sv
// Memory-mapped 4-phase wave-drive stepper controller on the data-memory bus.
// Registers: CTRL, PERIOD, STEPS and STATUS in a four-word window; load data is returned one cycle later.
module stepper_mmio #(
  parameter logic [11:0] BASE_ADDR = 12'hFF0,
  parameter int          PERIOD_W  = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  stepper_mmio_if.slave        bus,
  output logic                 busy,
  output logic [5:0]           JA
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic                en;
  logic                dir;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic [31:0]         remaining;
  logic [1:0]          phase;
  logic                done;
  logic [31:0]         q_reg;

  logic [1:0]          offset;
  logic                wr_ctrl;
  logic                wr_period;
  logic                wr_steps;
  logic                advance;
  logic [PERIOD_W-1:0] period_in;
  logic [31:0]         rd_data;
  logic                unused_addr;

  assign offset      = bus.address_dmem[1:0];
  assign bus.hit     = (bus.address_dmem[11:2] == BASE_ADDR[11:2]);
  assign unused_addr = ^bus.address_dmem[31:12];

  assign wr_ctrl   = bus.wren && bus.hit && (offset == 2'd0);
  assign wr_period = bus.wren && bus.hit && (offset == 2'd1);
  assign wr_steps  = bus.wren && bus.hit && (offset == 2'd2);

  // Periods below 2 would make the counter reach 1 immediately after every reload.
  assign period_in = (bus.data[PERIOD_W-1:0] < PERIOD_W'(2)) ? PERIOD_W'(2)
                                                              : bus.data[PERIOD_W-1:0];

  assign advance = (state == RUN) && en && (counter <= PERIOD_W'(1));

  always_comb begin
    rd_data = 32'd0;
    case (offset)
      2'd0:    rd_data = {30'd0, dir, en};
      2'd1:    rd_data = 32'(period);
      2'd2:    rd_data = remaining;
      default: rd_data = {29'd0, phase, (state == RUN)};
    endcase
  end

  // A STEPS store overrides the advance bookkeeping on the same edge, but the phase still steps.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      en        <= 1'b0;
      dir       <= 1'b0;
      period    <= PERIOD_W'(2);
      counter   <= '0;
      remaining <= 32'd0;
      phase     <= 2'd0;
      done      <= 1'b0;
      q_reg     <= 32'd0;
    end else begin
      done  <= 1'b0;
      q_reg <= bus.hit ? rd_data : 32'd0;

      if (wr_ctrl) begin
        en  <= bus.data[0];
        dir <= bus.data[1];
      end

      if (wr_period)
        period <= period_in;

      if (advance)
        phase <= dir ? (phase - 2'd1) : (phase + 2'd1);

      if (wr_steps) begin
        remaining <= bus.data;
        counter   <= period;
        state     <= (bus.data != 32'd0) ? RUN : IDLE;
      end else if ((state == RUN) && en) begin
        if (advance) begin
          remaining <= remaining - 32'd1;
          counter   <= period;
          if (remaining == 32'd1) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end else begin
          counter <= counter - PERIOD_W'(1);
        end
      end
    end
  end

  assign bus.q_mmio = q_reg;
  assign busy       = (state == RUN);
  assign JA         = {done, busy, (en ? (4'b0001 << phase) : 4'b0000)};

endmodule

// File: tb/tb_stepper_mmio.sv
// Directed, table-driven bench for stepper_mmio: register access vectors plus multi-cycle move sequences.
module tb_stepper_mmio;

  logic       clock;
  logic       reset;
  logic       busy;
  logic [5:0] JA;

  stepper_mmio_if bus ();

  stepper_mmio #(.BASE_ADDR(12'hFF0), .PERIOD_W(24)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .JA    (JA)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_q;
    logic [31:0] exp_q;
    logic        exp_hit;
    logic [5:0]  exp_ja;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] A_CTRL   = 32'hFF0;
  localparam logic [31:0] A_PERIOD = 32'hFF1;
  localparam logic [31:0] A_STEPS  = 32'hFF2;
  localparam logic [31:0] A_STATUS = 32'hFF3;

  function automatic logic [3:0] one_hot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.wren         = w;
    bus.address_dmem = a;
    bus.data         = d;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkJa(input string name, input logic [5:0] expected);
    checkOutput(name, {26'd0, JA}, {26'd0, expected});
  endtask

  logic [1:0] ph;
  logic [5:0] exp_d [7];
  int         pulses;

  initial begin
    bus.wren = 1'b0;
    bus.address_dmem = 32'd0;
    bus.data = 32'd0;
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0);
    checkJa("reset_ja", 6'h00);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_q", bus.q_mmio, 32'd0);
    reset = 1'b0;

    // wr, addr, data, chk_q, exp_q, exp_hit, exp_ja
    vecs.push_back('{1'b0, A_PERIOD,       32'h0,        1'b1, 32'd2, 1'b1, 6'h00});
    vecs.push_back('{1'b0, A_STATUS,       32'h0,        1'b1, 32'd0, 1'b1, 6'h00});
    vecs.push_back('{1'b0, A_CTRL,         32'h0,        1'b1, 32'd0, 1'b1, 6'h00});
    vecs.push_back('{1'b1, A_PERIOD,       32'd7,        1'b0, 32'd0, 1'b1, 6'h00});
    vecs.push_back('{1'b0, A_PERIOD,       32'h0,        1'b1, 32'd7, 1'b1, 6'h00});
    vecs.push_back('{1'b1, A_PERIOD,       32'd0,        1'b0, 32'd0, 1'b1, 6'h00});
    vecs.push_back('{1'b0, A_PERIOD,       32'h0,        1'b1, 32'd2, 1'b1, 6'h00});
    vecs.push_back('{1'b1, A_PERIOD,       32'd1,        1'b0, 32'd0, 1'b1, 6'h00});
    vecs.push_back('{1'b0, 32'h1234_5FF1,  32'h0,        1'b1, 32'd2, 1'b1, 6'h00});
    vecs.push_back('{1'b1, A_STEPS,        32'd0,        1'b0, 32'd0, 1'b1, 6'h00});
    vecs.push_back('{1'b0, A_STEPS,        32'h0,        1'b1, 32'd0, 1'b1, 6'h00});
    vecs.push_back('{1'b1, A_CTRL,         32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, 6'h01});
    vecs.push_back('{1'b0, A_CTRL,         32'h0,        1'b1, 32'd3, 1'b1, 6'h01});
    vecs.push_back('{1'b1, A_STATUS,       32'hFF,       1'b0, 32'd0, 1'b1, 6'h01});
    vecs.push_back('{1'b0, A_STATUS,       32'h0,        1'b1, 32'd0, 1'b1, 6'h01});
    vecs.push_back('{1'b0, 32'h0000_0000,  32'h0,        1'b1, 32'd0, 1'b0, 6'h01});
    vecs.push_back('{1'b1, 32'h0000_0FF4,  32'd0,        1'b1, 32'd0, 1'b0, 6'h01});
    vecs.push_back('{1'b0, A_CTRL,         32'h0,        1'b1, 32'd3, 1'b1, 6'h01});
    vecs.push_back('{1'b1, 32'h0000_0FEF,  32'd9,        1'b1, 32'd0, 1'b0, 6'h01});
    vecs.push_back('{1'b1, 32'h0000_0FED,  32'd9,        1'b1, 32'd0, 1'b0, 6'h01});
    vecs.push_back('{1'b0, A_PERIOD,       32'h0,        1'b1, 32'd2, 1'b1, 6'h01});
    vecs.push_back('{1'b1, A_CTRL,         32'd0,        1'b0, 32'd0, 1'b1, 6'h00});
    vecs.push_back('{1'b0, A_CTRL,         32'h0,        1'b1, 32'd0, 1'b1, 6'h00});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d_hit", i), {31'd0, bus.hit}, {31'd0, vecs[i].exp_hit});
      checkJa($sformatf("vec%0d_ja", i), vecs[i].exp_ja);
      if (vecs[i].chk_q)
        checkOutput($sformatf("vec%0d_q", i), bus.q_mmio, vecs[i].exp_q);
    end

    // Forward move: 4 steps of period 5, phases 1,2,3,0.
    applyStimulus(1'b1, A_CTRL, 32'd1);
    applyStimulus(1'b1, A_PERIOD, 32'd5);
    applyStimulus(1'b1, A_STEPS, 32'd4);
    checkJa("fwd_start", 6'h11);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, A_STEPS, 32'd0);
      ph = 2'((k / 5) % 4);
      checkJa($sformatf("fwd_ja_%0d", k), {(k == 20), (k < 20), one_hot(ph)});
      checkOutput($sformatf("fwd_rem_%0d", k), bus.q_mmio, 32'(4 - (k - 1) / 5));
    end
    applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("fwd_after", 6'h01);

    // Reverse move with PERIOD clamped to 2: phases 3,2,1.
    applyStimulus(1'b1, A_CTRL, 32'd3);
    applyStimulus(1'b1, A_PERIOD, 32'd0);
    applyStimulus(1'b0, A_PERIOD, 32'd0);
    checkOutput("rev_period", bus.q_mmio, 32'd2);
    applyStimulus(1'b1, A_STEPS, 32'd3);
    checkJa("rev_start", 6'h11);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, A_STATUS, 32'd0);
      ph = 2'(0 - k / 2);
      checkJa($sformatf("rev_ja_%0d", k), {(k == 6), (k < 6), one_hot(ph)});
      checkOutput($sformatf("rev_status_%0d", k), bus.q_mmio, {29'd0, 2'(0 - (k - 1) / 2), 1'b1});
    end
    applyStimulus(1'b0, A_STATUS, 32'd0);
    checkJa("rev_after", 6'h02);

    // Pause: en cleared on edge N+6 for 10 cycles, resume finishes at original spacing.
    applyStimulus(1'b1, A_CTRL, 32'd1);
    applyStimulus(1'b1, A_PERIOD, 32'd4);
    applyStimulus(1'b1, A_STEPS, 32'd3);
    checkJa("pause_start", 6'h12);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("pause_first_adv", 6'h14);
    applyStimulus(1'b1, A_CTRL, 32'd0);
    checkJa("pause_off", 6'h10);
    for (int k = 7; k <= 15; k++) begin
      applyStimulus(1'b0, A_STEPS, 32'd0);
      checkJa($sformatf("pause_ja_%0d", k), 6'h10);
      checkOutput($sformatf("pause_rem_%0d", k), bus.q_mmio, 32'd2);
    end
    applyStimulus(1'b1, A_CTRL, 32'd1);
    checkJa("pause_resume", 6'h14);
    applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("pause_n17", 6'h14);
    applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("pause_n18", 6'h18);
    for (int k = 19; k <= 21; k++) applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("pause_n21", 6'h18);
    applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("pause_done", 6'h21);
    applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("pause_after", 6'h01);

    // STEPS=2 written on the edge of the third advance of a 10-step move.
    applyStimulus(1'b1, A_PERIOD, 32'd3);
    applyStimulus(1'b1, A_STEPS, 32'd10);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, A_STEPS, 32'd0);
      checkJa($sformatf("ovr_ja_%0d", k), {1'b0, 1'b1, one_hot(2'(k / 3))});
    end
    applyStimulus(1'b1, A_STEPS, 32'd2);
    checkJa("ovr_write_edge", 6'h18);
    exp_d = '{6'h18, 6'h18, 6'h11, 6'h11, 6'h11, 6'h22, 6'h02};
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, A_STEPS, 32'd0);
      checkJa($sformatf("ovr_tail_%0d", k + 10), exp_d[k]);
      if (k == 0) checkOutput("ovr_rem", bus.q_mmio, 32'd2);
      if (JA[5]) pulses++;
    end
    checkOutput("ovr_pulses", 32'(pulses), 32'd1);

    // STEPS=0 mid-move aborts with no done pulse.
    applyStimulus(1'b1, A_STEPS, 32'd5);
    checkJa("abort_start", 6'h12);
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("abort_adv", 6'h14);
    applyStimulus(1'b1, A_STEPS, 32'd0);
    checkJa("abort_edge", 6'h04);
    applyStimulus(1'b0, A_STATUS, 32'd0);
    checkJa("abort_after", 6'h04);
    checkOutput("abort_status", bus.q_mmio, 32'd4);

    // Maximum count, then reset mid-move.
    applyStimulus(1'b1, A_STEPS, 32'hFFFF_FFFF);
    applyStimulus(1'b0, A_STEPS, 32'd0);
    checkOutput("max_rem", bus.q_mmio, 32'hFFFF_FFFF);
    checkJa("max_ja", 6'h14);
    reset = 1'b1;
    applyStimulus(1'b0, A_STEPS, 32'd0);
    checkJa("rst_ja", 6'h00);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_q", bus.q_mmio, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, A_PERIOD, 32'd0);
    checkOutput("rst_period", bus.q_mmio, 32'd2);
    applyStimulus(1'b0, A_STEPS, 32'd0);
    checkOutput("rst_rem", bus.q_mmio, 32'd0);
    applyStimulus(1'b0, A_CTRL, 32'd0);
    checkOutput("rst_ctrl", bus.q_mmio, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
